// File: rtl/vinho_serial_pkg.sv
// Shared definitions for the vinho serial link (transmitter and receiver).
// SERIALIZADOR_PARIDADE_EN adds the PARITY_BIT state to the encoding.
package vinho_serial_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 8;
    localparam int unsigned DEFAULT_BIT_CYCLES = 4;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
`ifdef SERIALIZADOR_PARIDADE_EN
        PARITY_BIT = 3'd3,
`endif
        STOP_BIT   = 3'd4
    } serial_state_t;

endpackage

// File: rtl/serializador_tx_if.sv
// Parallel-side handshake and serial line of serializador_tx.
interface serializador_tx_if
    import vinho_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] DATA_IN;
    logic             START;
    logic             READY;
    logic             SDATA;
    logic             BUSY;
    logic             DONE;

    modport master (output DATA_IN, START, input READY, SDATA, BUSY, DONE);
    modport slave  (input DATA_IN, START, output READY, SDATA, BUSY, DONE);
endinterface

// File: rtl/serializador_tx_contador_bit.sv
// Bit-time counter: counts 0..BIT_CYCLES-1 while enabled, ticks on the last cycle.
module contador_bit #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    // With BIT_CYCLES=1 the count stays at 0 and every enabled cycle is a boundary.
    assign tick = en && (cnt_q == CW'(BIT_CYCLES - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/serializador_tx.sv
// Framed LSB-first serial transmitter: start, WIDTH data bits, [parity], stop.
// Define SERIALIZADOR_PARIDADE_EN to insert an even-parity bit before the stop bit.
module serializador_tx
    import vinho_serial_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic              CLOCK,
    input  logic              RESET,
    serializador_tx_if.slave  bus
);
    localparam int unsigned IW = $clog2(WIDTH);

    serial_state_t    state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [IW-1:0]    idx_q;
    logic             done_q;
    logic             tick;
    logic             accept;
    logic             last_bit;
    logic             sdata;
`ifdef SERIALIZADOR_PARIDADE_EN
    logic             par_q;
`endif

    assign accept   = (state_q == IDLE) && bus.START;
    assign last_bit = (idx_q == IW'(WIDTH - 1));

    contador_bit #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_contador_bit (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .en    (state_q != IDLE),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.START) state_d = START_BIT;
            START_BIT: if (tick) state_d = DATA_BITS;
            DATA_BITS: begin
                if (tick && last_bit) begin
`ifdef SERIALIZADOR_PARIDADE_EN
                    state_d = PARITY_BIT;
`else
                    state_d = STOP_BIT;
`endif
                end
            end
`ifdef SERIALIZADOR_PARIDADE_EN
            PARITY_BIT: if (tick) state_d = STOP_BIT;
`endif
            STOP_BIT:  if (tick) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        sdata = IDLE_LEVEL;
        case (state_q)
            START_BIT:  sdata = START_LEVEL;
            DATA_BITS:  sdata = shreg_q[0];
`ifdef SERIALIZADOR_PARIDADE_EN
            PARITY_BIT: sdata = par_q;
`endif
            STOP_BIT:   sdata = STOP_LEVEL;
            default:    sdata = IDLE_LEVEL;
        endcase
    end

    // Parity is taken from the word at accept time because the shift register is consumed.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef SERIALIZADOR_PARIDADE_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == STOP_BIT) && tick;
            if (accept) begin
                shreg_q <= bus.DATA_IN;
`ifdef SERIALIZADOR_PARIDADE_EN
                par_q   <= ^bus.DATA_IN;
`endif
            end else if ((state_q == DATA_BITS) && tick) begin
                shreg_q <= shreg_q >> 1;
                idx_q   <= last_bit ? '0 : idx_q + IW'(1);
            end
        end
    end

    assign bus.SDATA = sdata;
    assign bus.READY = (state_q == IDLE);
    assign bus.BUSY  = (state_q != IDLE);
    assign bus.DONE  = done_q;
endmodule

// File: tb/tb_serializador_tx.sv
// Scoreboard bench for serializador_tx: stimulus queues hand-computed frames,
// a line monitor decodes SDATA and compares each completed frame.
module tb_serializador_tx;
    localparam int unsigned W  = 8;
    localparam int unsigned BC = 4;
`ifdef SERIALIZADOR_PARIDADE_EN
    localparam int NB        = 11;
    localparam int FRAME_CYC = 44;
`else
    localparam int NB        = 10;
    localparam int FRAME_CYC = 40;
`endif

    logic CLOCK;
    logic RESET;
    int   cyc;
    int   total;
    int   bad;

    string q_bits[$];
    int    q_acc[$];

    serializador_tx_if #(.WIDTH(W)) bus();

    serializador_tx #(
        .WIDTH      (W),
        .BIT_CYCLES (BC)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Transmitted order, first character on the line first.
    function automatic string exp_bits(input logic [7:0] d);
        case (d)
`ifdef SERIALIZADOR_PARIDADE_EN
            8'hA5:   return "01010010101";
            8'h01:   return "01000000011";
            8'h80:   return "00000000111";
            8'h3C:   return "00011110001";
            8'h07:   return "01110000011";
`else
            8'hA5:   return "0101001011";
            8'h01:   return "0100000001";
            8'h80:   return "0000000011";
            8'h3C:   return "0001111001";
            8'h07:   return "0111000001";
`endif
            default: return "";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit expect_frame, output int acc);
        bus.DATA_IN = d;
        bus.START   = 1'b1;
        acc         = cyc;
        if (expect_frame) begin
            q_bits.push_back(exp_bits(d));
            q_acc.push_back(acc);
        end
        @(negedge CLOCK);
        bus.START   = 1'b0;
        bus.DATA_IN = ~d;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK);
            if (bus.DONE === 1'b1) begin
                dcyc = cyc;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    initial begin : monitor
        logic        prev_sd;
        logic        aborted;
        logic [15:0] rv;
        logic [15:0] ev;
        logic [3:0]  done_ok;
        int          start_cyc;
        int          hs_err;
        int          hold_err;
        int          ea;
        string       eb;
        prev_sd = 1'b1;
        forever begin
            @(negedge CLOCK);
            if (RESET) begin
                prev_sd = 1'b1;
            end else if (prev_sd && (bus.SDATA === 1'b0)) begin
                start_cyc = cyc;
                rv        = '0;
                hs_err    = 0;
                hold_err  = 0;
                aborted   = 1'b0;
                for (int b = 0; b < NB && !aborted; b++) begin
                    for (int c = 0; c < BC && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge CLOCK);
                        if (RESET) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) rv[b] = bus.SDATA;
                            else if (bus.SDATA !== rv[b]) hold_err++;
                            if (bus.READY !== 1'b0 || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0)
                                hs_err++;
                        end
                    end
                end
                if (!aborted) begin
                    @(negedge CLOCK);
                    done_ok = {bus.DONE, bus.READY, bus.BUSY, bus.SDATA};
                    if (q_bits.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        eb = q_bits.pop_front();
                        ea = q_acc.pop_front();
                        ev = '0;
                        for (int i = 0; i < NB; i++) ev[i] = (eb.getc(i) == 8'h31);
                        check("frame_bits", 32'(rv), 32'(ev));
                        check("start_latency", start_cyc, ea + 1);
                        check("bit_hold", hold_err, 0);
                        check("frame_handshake", hs_err, 0);
                        check("done_pulse", 32'(done_ok), 32'h0000_000D);
                    end
                end
                prev_sd = 1'b1;
            end else begin
                prev_sd = bus.SDATA;
            end
        end
    end

    initial begin : stimulus
        int acc;
        int dcyc;
        int nbusy;
        int ndone;
        total       = 0;
        bad         = 0;
        RESET       = 1'b1;
        bus.START   = 1'b0;
        bus.DATA_IN = '0;

        // Reset and idle line.
        repeat (3) @(negedge CLOCK);
        check("reset_outputs", 32'({bus.SDATA, bus.READY, bus.BUSY, bus.DONE}), 32'h0000_000C);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            check("idle_outputs", 32'({bus.SDATA, bus.READY, bus.BUSY, bus.DONE}), 32'h0000_000C);
        end

        // Single frame with a rejected START while busy.
        send(8'hA5, 1'b1, acc);
        while (cyc < acc + 10) @(negedge CLOCK);
        bus.DATA_IN = 8'hFF;
        bus.START   = 1'b1;
        check("busy_ready_low", 32'(bus.READY), 0);
        @(negedge CLOCK);
        bus.START = 1'b0;
        wait_done(FRAME_CYC + 10, dcyc);
        check("done_cycle", dcyc - acc, FRAME_CYC + 1);
        nbusy = 0;
        repeat (6) begin
            @(negedge CLOCK);
            if (bus.BUSY !== 1'b0) nbusy++;
        end
        check("no_second_frame", nbusy, 0);

        // Back-to-back: second START issued in the DONE cycle.
        @(negedge CLOCK);
        send(8'h01, 1'b1, acc);
        wait_done(FRAME_CYC + 10, dcyc);
        check("gap_idle_high", 32'(bus.SDATA), 1);
        send(8'h80, 1'b1, acc);
        check("gap_start_low", 32'(bus.SDATA), 0);
        wait_done(FRAME_CYC + 10, dcyc);

        // Reset mid-frame, with START competing on the same edge.
        @(negedge CLOCK);
        send(8'h3C, 1'b0, acc);
        while (cyc < acc + 15) @(negedge CLOCK);
        RESET       = 1'b1;
        bus.START   = 1'b1;
        bus.DATA_IN = 8'hFF;
        @(negedge CLOCK);
        check("midreset_outputs", 32'({bus.SDATA, bus.READY, bus.BUSY, bus.DONE}), 32'h0000_000C);
        bus.START = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        nbusy = 0;
        ndone = 0;
        repeat (FRAME_CYC) begin
            @(negedge CLOCK);
            if (bus.BUSY !== 1'b0) nbusy++;
            if (bus.DONE !== 1'b0) ndone++;
        end
        check("aborted_no_done", ndone, 0);
        check("aborted_no_busy", nbusy, 0);
        send(8'h3C, 1'b1, acc);
        wait_done(FRAME_CYC + 10, dcyc);

        // Odd-weight word (parity bit 1 when enabled).
        @(negedge CLOCK);
        send(8'h07, 1'b1, acc);
        wait_done(FRAME_CYC + 10, dcyc);
        check("done_cycle_07", dcyc - acc, FRAME_CYC + 1);

        repeat (5) @(negedge CLOCK);
        check("queue_drained", q_bits.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serializador_tx.md
Name: serializador_tx

Overview:
- Parallel-in, serial-out transmitter: accepts a WIDTH-bit sensor/control word and drives it onto a single-wire serial line as a framed bit stream.
- Transmit end of the bit-level link whose receive side captures SDATA in flip-flop-based shift registers clocked by the shared CLOCK.
- Frame format, LSB first:
  - one start bit (0);
  - WIDTH data bits;
  - optional parity bit;
  - one stop bit (1).
- Line idles high.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
BIT_CYCLES, 4, CLOCK cycles per serial bit (>= 1)

Ports:
CLOCK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset, sampled on rising edge of CLOCK
DATA_IN  input  WIDTH  word to transmit, sampled when START && READY
START  input  1  request to send DATA_IN
READY  output  1  high when idle and able to accept a word
SDATA  output  1  serial line, idle high
BUSY  output  1  high while a frame is on the line
DONE  output  1  one-cycle pulse, high on the first idle cycle after the stop bit

Behaviour:
- One clock domain (CLOCK). Reset is synchronous and active-high (RESET).
- Reset values: READY=1, SDATA=1, BUSY=0, DONE=0, state=IDLE, counters=0, shift register=0.
- Handshake:
  - Transfer occurs on a rising edge where START=1 and READY=1; DATA_IN is latched into the shift register on that edge.
  - START with READY=0 is ignored; no queuing.
- FSM states: IDLE, START_BIT, DATA_BITS, PARITY_BIT (feature only), STOP_BIT.
- IDLE:
  - Outputs: SDATA=1, READY=1, BUSY=0.
  - On accept: go to START_BIT, READY=0 and BUSY=1 from the next cycle.
- START_BIT: SDATA=0 for BIT_CYCLES cycles, then go to DATA_BITS.
- DATA_BITS:
  - SDATA = shift register bit 0. Each bit is held BIT_CYCLES cycles.
  - Shift right by one at each bit boundary.
  - After WIDTH bits: go to PARITY_BIT if enabled, else STOP_BIT.
- STOP_BIT: SDATA=1 for BIT_CYCLES cycles, then go to IDLE.
- DONE:
  - High exactly in the first IDLE cycle after STOP_BIT (the same cycle READY returns to 1).
  - Low in every other cycle.
- Latency:
  - First start-bit cycle is the cycle after accept.
  - Frame length = (WIDTH+2)*BIT_CYCLES cycles, plus BIT_CYCLES when parity is enabled.
- Counters:
  - Bit-time counter counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary.
  - Bit-index counter counts 0..WIDTH-1, width ceil(log2(WIDTH)), wraps to 0 on leaving DATA_BITS.
  - BIT_CYCLES=1: one cycle per bit, no stall cycles.
- Back-to-back: START=1 in the DONE cycle is accepted. The next start bit begins on the following cycle, giving exactly one idle-high cycle between frames.
- DATA_IN changing after accept has no effect on the frame in flight.
- RESET mid-frame:
  - Frame is aborted; all outputs take reset values on that edge.
  - No DONE pulse for the aborted frame.
  - RESET has priority over START on the same edge.

Optional Feature:
- Macro: SERIALIZADOR_PARIDADE_EN.
- Defined:
  - PARITY_BIT state is inserted between DATA_BITS and STOP_BIT.
  - SDATA = even parity (XOR of the WIDTH latched data bits), held BIT_CYCLES cycles.
  - Frame length becomes (WIDTH+3)*BIT_CYCLES.
- Undefined:
  - No PARITY_BIT state and no parity logic.
  - DATA_BITS goes directly to STOP_BIT.

Decomposition:
- Shared package vinho_serial_pkg, which the matching receiver also uses. It holds:
  - state encoding typedef;
  - START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1;
  - default WIDTH and BIT_CYCLES constants.
- Sub-module contador_bit, instantiated once: bit-time counter with enable and synchronous clear, outputs a bit-boundary tick.
- FSM, shift register and bit-index counter stay in serializador_tx.

Test Plan:
- Reset/idle:
  - Stimulus: RESET=1 for 3 cycles, then low for 10 cycles with START=0.
  - Required: SDATA=1, READY=1, BUSY=0, DONE=0 throughout.
- Single frame (WIDTH=8, BIT_CYCLES=4):
  - Stimulus: DATA_IN=8'hA5 with START pulsed one cycle.
  - Required: SDATA sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles (40 cycles total).
  - Required: DONE high on cycle 41 after accept; READY low from cycle 1 through 40.
- Busy rejection:
  - Stimulus: during 8'hA5 frame, START=1 with DATA_IN=8'hFF at cycle 10.
  - Required: frame bits unchanged; no second frame starts.
- Back-to-back:
  - Stimulus: 8'h01 then 8'h80, second START asserted in the DONE cycle.
  - Required: exactly one SDATA=1 idle cycle between the stop bit of frame 1 and the start bit of frame 2.
- Reset mid-frame:
  - Stimulus: RESET=1 at cycle 15 of a 8'h3C frame.
  - Required: next cycle SDATA=1, READY=1, BUSY=0; no DONE pulse.
  - Required: new START afterwards produces a full correct frame.
- Parity (SERIALIZADOR_PARIDADE_EN defined):
  - Stimulus: 8'hA5.
  - Required: parity bit 0, frame 44 cycles.
  - Stimulus: 8'h07.
  - Required: parity bit 1.
